control_unit_irq: RTL and testbench
===================================

Name: control_unit_irq

Overview:
Parametrised hardwired control unit for the accumulator CPU, and the successor to the fixed 16-bit unit. It generates per-cycle register strobes, a binary-encoded bus select, the ALU op code and memory read/write strobes from IR, the sequence counter and datapath status. It adds indirect addressing, I/O instructions, an interrupt cycle, HLT, and a memory wait-state handshake that stalls the sequence counter.

Parameters:
DATA_W, 16, datapath/instruction width (≥16); I = ir[DATA_W-1], opcode = ir[DATA_W-2:DATA_W-4], address = ir[DATA_W-5:0]
SC_W, 4, sequence counter width (≥3); T-decoder has 2**SC_W outputs

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
ir  in  DATA_W  instruction register contents
ac  in  DATA_W  accumulator value
e  in  1  E flip-flop value
dr  in  DATA_W  data register value
fgi  in  1  input flag (INPR holds data)
fgo  in  1  output flag (OUTR empty)
mem_ready  in  1  memory completes the current read/write this cycle
ld  out  6  load strobes {AR,PC,DR,AC,IR,TR}
inr  out  4  increment strobes {AR,PC,DR,AC}
clr  out  4  clear strobes {AR,PC,DR,AC}
e_ctl  out  2  {clear E, complement E}
alu_op  out  3  0 none, 1 AND, 2 ADD, 3 DR, 4 INPR, 5 COM, 6 SHR, 7 SHL
bus_sel  out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
mem_rd  out  1  memory read
mem_wr  out  1  memory write
fgi_clr  out  1  clear FGI
fgo_clr  out  1  clear FGO
outr_ld  out  1  load OUTR from AC
ien  out  1  interrupt enable flip-flop
halted  out  1  HLT executed
sc  out  SC_W  sequence counter (debug)

Behaviour:
- State: SC, R (interrupt-cycle flag), IEN, HALT, IND (latched I bit). All outputs except sc/ien/halted are combinational from state and inputs.
- Reset (reset=0 at clk edge): SC=0, R=0, IEN=0, HALT=0, IND=0. While reset=0, all strobes are 0 except clr[PC]=1.
- Decode: D = 3→8 decode of the opcode; T = decode of SC.
- Fetch with R=0:
  - T0: bus_sel=PC, ld AR.
  - T1: bus_sel=MEM, mem_rd, ld IR, inr PC.
  - T2: bus_sel=IR, ld AR, IND←I.
- Indirect: D7'·IND·T3: bus_sel=MEM, mem_rd, ld AR. D7'·IND'·T3 does nothing.
- Memory-reference instructions (D0..D6, T4 onward):
  - AND/ADD/LDA: T4 MEM→DR (mem_rd); T5 alu_op=1/2/3, ld AC, SC←0.
  - STA: T4 bus AC, mem_wr, SC←0.
  - BUN: T4 bus AR, ld PC, SC←0.
  - BSA: T4 bus PC, mem_wr, inr AR; T5 bus AR, ld PC, SC←0.
  - ISZ: T4 MEM→DR; T5 inr DR; T6 bus DR, mem_wr, inr PC if dr==0, SC←0.
- Register-reference, D7·IND'·T3, SC←0:
  - bit 11 CLA: clr AC. Bit 10 CLE, bit 8 CME: e_ctl.
  - bit 9 CMA, bit 7 CIR, bit 6 CIL: ld AC with alu_op priority COM>SHR>SHL.
  - bit 5 INC: inr AC.
  - Skips inr PC once if any selected condition holds: bit 4 SPA (ac MSB 0), bit 3 SNA (MSB 1), bit 2 SZA (ac==0), bit 1 SZE (e==0).
  - bit 0 HLT: HALT←1.
- I/O, D7·IND·T3, SC←0:
  - bit 11 INP: alu_op=4, ld AC, fgi_clr.
  - bit 10 OUT: bus AC, outr_ld, fgo_clr.
  - bit 9 SKI: inr PC if fgi. Bit 8 SKO: inr PC if fgo.
  - bit 7 ION: IEN←1. Bit 6 IOF: IEN←0 (IOF wins if both set).
- Interrupt request: at any clk edge with SC∉{0,1,2}, R=0 and IEN·(fgi|fgo), R←1.
- Interrupt cycle (R=1):
  - T0: clr AR, bus PC, ld TR.
  - T1: bus TR, mem_wr, clr PC.
  - T2: inr PC, IEN←0, R←0, SC←0.
- Wait states: in any step asserting mem_rd/mem_wr, the strobe and bus_sel hold while mem_ready=0. ld/inr/clr/e_ctl/flag clears stay 0 and no state changes until mem_ready=1, when the step completes normally.
- HALT=1: SC frozen, all strobes 0 until reset. Interrupts do not wake the unit.
- SC otherwise increments each cycle and wraps modulo 2**SC_W; no legal path exceeds T6.

Optional Feature:
CU_IRQ_EN: defined → interrupt request logic, R cycle, ION/IOF as above. Undefined → R and IEN tied 0, ION/IOF are no-ops, ien output 0, fetch always taken.

Test Plan:
- Reset low 2 cycles then high, mem_ready=1: sc=0, clr[PC] high during reset. First cycles: T0 ld AR + bus_sel=2, T1 mem_rd + ld IR + inr PC.
- ir=16'h1123 (ADD direct): T4 mem_rd + ld DR, T5 alu_op=2 + ld AC, sc returns to 0 at the next edge. Total 6 cycles.
- ir=16'h9123 (ADD indirect) with mem_ready low 3 cycles at T3: ld AR held 0 and sc=3 for 3 cycles, then ld AR on the ready cycle. Instruction completes at T5.
- ir=16'h6040 (ISZ) with dr=0 at T6: mem_wr, bus_sel=3, inr PC. Same with dr=1: no inr PC.
- CU_IRQ_EN, ION executed, fgi=1 during the next instruction: R set. Following T0..T2 show clr AR/ld TR, mem_wr/clr PC, inr PC. ien=0 afterwards.
- ir=16'h7001 (HLT): halted=1, sc stays 0, no strobes for 10 cycles. Reset clears halted.

Source files
------------

// File: rtl/control_unit_irq.sv
// Hardwired control unit for the accumulator CPU: fetch/indirect/execute sequencing, I/O, HLT and
// memory wait states. Define CU_IRQ_EN to build in the interrupt request logic, R cycle and ION/IOF.
module control_unit_irq #(
    parameter int DATA_W = 16,
    parameter int SC_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] ac,
    input  logic              e,
    input  logic [DATA_W-1:0] dr,
    input  logic              fgi,
    input  logic              fgo,
    input  logic              mem_ready,
    output logic [5:0]        ld,
    output logic [3:0]        inr,
    output logic [3:0]        clr,
    output logic [1:0]        e_ctl,
    output logic [2:0]        alu_op,
    output logic [2:0]        bus_sel,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              fgi_clr,
    output logic              fgo_clr,
    output logic              outr_ld,
    output logic              ien,
    output logic              halted,
    output logic [SC_W-1:0]   sc
);
    localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3;
    localparam logic [2:0] BUS_AC = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7;
    localparam logic [2:0] ALU_NONE = 3'd0, ALU_AND = 3'd1, ALU_ADD = 3'd2, ALU_DR = 3'd3;
    localparam logic [2:0] ALU_INPR = 3'd4, ALU_COM = 3'd5, ALU_SHR = 3'd6, ALU_SHL = 3'd7;
    localparam int LD_AR = 5, LD_PC = 4, LD_DR = 3, LD_AC = 2, LD_IR = 1, LD_TR = 0;
    localparam int RG_AR = 3, RG_PC = 2, RG_DR = 1, RG_AC = 0;

    logic [SC_W-1:0] sc_r;
    logic            halt_r, ind_r, r_s, ien_s, stall_s;
    logic [2:0]      opcode_s;
    logic [7:0]      d_s, t_s;
    logic [5:0]      ld_s;
    logic [3:0]      inr_s, clr_s;
    logic [1:0]      e_ctl_s;
    logic [2:0]      alu_op_s, bus_sel_s;
    logic            mem_rd_s, mem_wr_s, fgi_clr_s, fgo_clr_s, outr_ld_s;
    logic            sc_clr_s, halt_set_s, ind_ld_s, skip_s;

    assign opcode_s = ir[DATA_W-2:DATA_W-4];
    assign d_s      = 8'd1 << opcode_s;
    // Only T0..T6 are reachable; higher counter values decode to no active step.
    assign t_s      = 8'd1 << sc_r;
    assign skip_s   = (ir[4] & ~ac[DATA_W-1]) | (ir[3] & ac[DATA_W-1]) |
                      (ir[2] & (ac == '0)) | (ir[1] & ~e);
    assign stall_s  = (mem_rd_s | mem_wr_s) & ~mem_ready;

`ifdef CU_IRQ_EN
    logic r_r, ien_r, ien_set_s, ien_clr_s, r_clr_s, irq_req_s;
    assign r_s       = r_r;
    assign ien_s     = ien_r;
    assign irq_req_s = ~r_r & (sc_r > SC_W'(2)) & ien_r & (fgi | fgo);

    // Interrupt-cycle flag and interrupt enable; frozen while halted or stalled on memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_r   <= 1'b0;
            ien_r <= 1'b0;
        end else if (halt_r || stall_s) begin
            r_r   <= r_r;
            ien_r <= ien_r;
        end else begin
            if (r_clr_s) r_r <= 1'b0;
            else if (irq_req_s) r_r <= 1'b1;
            else r_r <= r_r;
            if (ien_clr_s) ien_r <= 1'b0;
            else if (ien_set_s) ien_r <= 1'b1;
            else ien_r <= ien_r;
        end
    end
`else
    assign r_s   = 1'b0;
    assign ien_s = 1'b0;
`endif

    // Sequence counter, HALT and latched indirect bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sc_r   <= '0;
            halt_r <= 1'b0;
            ind_r  <= 1'b0;
        end else if (halt_r || stall_s) begin
            sc_r   <= sc_r;
            halt_r <= halt_r;
            ind_r  <= ind_r;
        end else begin
            sc_r   <= sc_clr_s ? '0 : sc_r + SC_W'(1);
            halt_r <= halt_set_s;
            ind_r  <= ind_ld_s ? ir[DATA_W-1] : ind_r;
        end
    end

    // Raw step decode from T, D, IND and R before reset/halt/wait gating.
    always_comb begin
        ld_s = 6'd0;  inr_s = 4'd0;  clr_s = 4'd0;  e_ctl_s = 2'd0;
        alu_op_s = ALU_NONE;  bus_sel_s = BUS_NONE;
        mem_rd_s = 1'b0;  mem_wr_s = 1'b0;  fgi_clr_s = 1'b0;  fgo_clr_s = 1'b0;
        outr_ld_s = 1'b0;  sc_clr_s = 1'b0;  halt_set_s = 1'b0;  ind_ld_s = 1'b0;
`ifdef CU_IRQ_EN
        ien_set_s = 1'b0;  ien_clr_s = 1'b0;  r_clr_s = 1'b0;
`endif
        if (r_s) begin
            if (t_s[0]) begin
                clr_s[RG_AR] = 1'b1;  bus_sel_s = BUS_PC;  ld_s[LD_TR] = 1'b1;
            end else if (t_s[1]) begin
                bus_sel_s = BUS_TR;  mem_wr_s = 1'b1;  clr_s[RG_PC] = 1'b1;
            end else if (t_s[2]) begin
                inr_s[RG_PC] = 1'b1;  sc_clr_s = 1'b1;
`ifdef CU_IRQ_EN
                ien_clr_s = 1'b1;  r_clr_s = 1'b1;
`endif
            end else begin
                sc_clr_s = 1'b0;
            end
        end else if (t_s[0]) begin
            bus_sel_s = BUS_PC;  ld_s[LD_AR] = 1'b1;
        end else if (t_s[1]) begin
            bus_sel_s = BUS_MEM;  mem_rd_s = 1'b1;  ld_s[LD_IR] = 1'b1;  inr_s[RG_PC] = 1'b1;
        end else if (t_s[2]) begin
            bus_sel_s = BUS_IR;  ld_s[LD_AR] = 1'b1;  ind_ld_s = 1'b1;
        end else if (t_s[3]) begin
            if (d_s[7] && !ind_r) begin
                clr_s[RG_AC] = ir[11];
                e_ctl_s      = {ir[10], ir[8]};
                if (ir[9]) alu_op_s = ALU_COM;
                else if (ir[7]) alu_op_s = ALU_SHR;
                else if (ir[6]) alu_op_s = ALU_SHL;
                else alu_op_s = ALU_NONE;
                ld_s[LD_AC]  = ir[9] | ir[7] | ir[6];
                inr_s[RG_AC] = ir[5];
                inr_s[RG_PC] = skip_s;
                halt_set_s   = ir[0];
                sc_clr_s     = 1'b1;
            end else if (d_s[7]) begin
                alu_op_s     = ir[11] ? ALU_INPR : ALU_NONE;
                ld_s[LD_AC]  = ir[11];
                fgi_clr_s    = ir[11];
                bus_sel_s    = ir[10] ? BUS_AC : BUS_NONE;
                outr_ld_s    = ir[10];
                fgo_clr_s    = ir[10];
                inr_s[RG_PC] = (ir[9] & fgi) | (ir[8] & fgo);
`ifdef CU_IRQ_EN
                ien_clr_s    = ir[6];
                ien_set_s    = ir[7] & ~ir[6];
`endif
                sc_clr_s     = 1'b1;
            end else if (ind_r) begin
                bus_sel_s = BUS_MEM;  mem_rd_s = 1'b1;  ld_s[LD_AR] = 1'b1;
            end else begin
                sc_clr_s = 1'b0;
            end
        end else if (d_s[0] || d_s[1] || d_s[2]) begin
            if (t_s[4]) begin
                bus_sel_s = BUS_MEM;  mem_rd_s = 1'b1;  ld_s[LD_DR] = 1'b1;
            end else if (t_s[5]) begin
                alu_op_s = d_s[0] ? ALU_AND : (d_s[1] ? ALU_ADD : ALU_DR);
                ld_s[LD_AC] = 1'b1;  sc_clr_s = 1'b1;
            end else begin
                sc_clr_s = 1'b0;
            end
        end else if (d_s[3]) begin
            if (t_s[4]) begin
                bus_sel_s = BUS_AC;  mem_wr_s = 1'b1;  sc_clr_s = 1'b1;
            end else begin
                sc_clr_s = 1'b0;
            end
        end else if (d_s[4]) begin
            if (t_s[4]) begin
                bus_sel_s = BUS_AR;  ld_s[LD_PC] = 1'b1;  sc_clr_s = 1'b1;
            end else begin
                sc_clr_s = 1'b0;
            end
        end else if (d_s[5]) begin
            if (t_s[4]) begin
                bus_sel_s = BUS_PC;  mem_wr_s = 1'b1;  inr_s[RG_AR] = 1'b1;
            end else if (t_s[5]) begin
                bus_sel_s = BUS_AR;  ld_s[LD_PC] = 1'b1;  sc_clr_s = 1'b1;
            end else begin
                sc_clr_s = 1'b0;
            end
        end else if (d_s[6]) begin
            if (t_s[4]) begin
                bus_sel_s = BUS_MEM;  mem_rd_s = 1'b1;  ld_s[LD_DR] = 1'b1;
            end else if (t_s[5]) begin
                inr_s[RG_DR] = 1'b1;
            end else if (t_s[6]) begin
                bus_sel_s = BUS_DR;  mem_wr_s = 1'b1;
                inr_s[RG_PC] = (dr == '0);  sc_clr_s = 1'b1;
            end else begin
                sc_clr_s = 1'b0;
            end
        end else begin
            sc_clr_s = 1'b0;
        end
    end

    // Output gating: reset forces PC clear, HALT silences everything, a wait state keeps only
    // the memory strobe and bus select alive.
    always_comb begin
        ld = 6'd0;  inr = 4'd0;  clr = 4'd0;  e_ctl = 2'd0;  alu_op = ALU_NONE;
        bus_sel = BUS_NONE;  mem_rd = 1'b0;  mem_wr = 1'b0;
        fgi_clr = 1'b0;  fgo_clr = 1'b0;  outr_ld = 1'b0;
        if (!reset) begin
            clr[RG_PC] = 1'b1;
        end else if (halt_r) begin
            clr = 4'd0;
        end else if (stall_s) begin
            bus_sel = bus_sel_s;  mem_rd = mem_rd_s;  mem_wr = mem_wr_s;
        end else begin
            ld = ld_s;  inr = inr_s;  clr = clr_s;  e_ctl = e_ctl_s;  alu_op = alu_op_s;
            bus_sel = bus_sel_s;  mem_rd = mem_rd_s;  mem_wr = mem_wr_s;
            fgi_clr = fgi_clr_s;  fgo_clr = fgo_clr_s;  outr_ld = outr_ld_s;
        end
    end

    assign ien    = ien_s;
    assign halted = halt_r;
    assign sc     = sc_r;
endmodule

// File: tb/tb_control_unit_irq.sv
// Scoreboard bench for control_unit_irq: hand-derived per-cycle control words are queued as each
// cycle's inputs are driven and compared against the DUT outputs mid low phase.
module tb_control_unit_irq;
    typedef struct packed {
        logic [5:0] ld;
        logic [3:0] inr;
        logic [3:0] clr;
        logic [1:0] e_ctl;
        logic [2:0] alu_op;
        logic [2:0] bus_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       fgi_clr;
        logic       fgo_clr;
        logic       outr_ld;
        logic       ien;
        logic       halted;
        logic [3:0] sc;
    } vec_t;

    localparam logic [5:0] L_AR = 6'b100000, L_PC = 6'b010000, L_DR = 6'b001000;
    localparam logic [5:0] L_AC = 6'b000100, L_IR = 6'b000010, L_TR = 6'b000001;
    localparam logic [3:0] R_AR = 4'b1000, R_PC = 4'b0100, R_DR = 4'b0010, R_AC = 4'b0001;

    logic        clk = 1'b0;
    logic        reset, e, fgi, fgo, mem_ready;
    logic [15:0] ir, ac, dr;
    logic [5:0]  ld;
    logic [3:0]  inr, clr, sc;
    logic [1:0]  e_ctl;
    logic [2:0]  alu_op, bus_sel;
    logic        mem_rd, mem_wr, fgi_clr, fgo_clr, outr_ld, ien, halted;

    vec_t sb_q[$];
    logic exp_ien;
    int   n_vec = 0;
    int   n_bad = 0;

    control_unit_irq dut (
        .clk(clk), .reset(reset), .ir(ir), .ac(ac), .e(e), .dr(dr), .fgi(fgi), .fgo(fgo),
        .mem_ready(mem_ready), .ld(ld), .inr(inr), .clr(clr), .e_ctl(e_ctl), .alu_op(alu_op),
        .bus_sel(bus_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .fgi_clr(fgi_clr),
        .fgo_clr(fgo_clr), .outr_ld(outr_ld), .ien(ien), .halted(halted), .sc(sc)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] l, input logic [3:0] i, input logic [3:0] c,
                                input logic [2:0] alu, input logic [2:0] bus,
                                input logic rd, input logic wr, input logic [3:0] s);
        vec_t v;
        v = '0;
        v.ld = l;  v.inr = i;  v.clr = c;  v.alu_op = alu;  v.bus_sel = bus;
        v.mem_rd = rd;  v.mem_wr = wr;  v.ien = exp_ien;  v.sc = s;
        return v;
    endfunction

    task automatic step(input string tag, input vec_t exp);
        vec_t got, want;
        sb_q.push_back(exp);
        #1;
        got = {ld, inr, clr, e_ctl, alu_op, bus_sel, mem_rd, mem_wr, fgi_clr, fgo_clr,
               outr_ld, ien, halted, sc};
        want = sb_q.pop_front();
        check_vec(tag, 64'(got), 64'(want));
        @(negedge clk);
    endtask

    task automatic fetch(input string p);
        step({p, "_t0"}, mk(L_AR, 4'd0, 4'd0, 3'd0, 3'd2, 1'b0, 1'b0, 4'd0));
        step({p, "_t1"}, mk(L_IR, R_PC, 4'd0, 3'd0, 3'd7, 1'b1, 1'b0, 4'd1));
        step({p, "_t2"}, mk(L_AR, 4'd0, 4'd0, 3'd0, 3'd5, 1'b0, 1'b0, 4'd2));
    endtask

    task automatic idle_t3(input string p);
        step(p, mk(6'd0, 4'd0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset = 1'b0;  ir = 16'h0000;  ac = 16'h0000;  dr = 16'h0000;  e = 1'b0;
        fgi = 1'b0;  fgo = 1'b0;  mem_ready = 1'b1;  exp_ien = 1'b0;
        @(negedge clk);
        v = mk(6'd0, 4'd0, R_PC, 3'd0, 3'd0, 1'b0, 1'b0, 4'd0);
        step("rst0", v);
        step("rst1", v);
        reset = 1'b1;

        ir = 16'h1123;
        fetch("add");
        idle_t3("add_t3");
        step("add_t4", mk(L_DR, 4'd0, 4'd0, 3'd0, 3'd7, 1'b1, 1'b0, 4'd4));
        step("add_t5", mk(L_AC, 4'd0, 4'd0, 3'd2, 3'd0, 1'b0, 1'b0, 4'd5));

        ir = 16'h9123;
        fetch("addi");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("addi_wait", mk(6'd0, 4'd0, 4'd0, 3'd0, 3'd7, 1'b1, 1'b0, 4'd3));
        mem_ready = 1'b1;
        step("addi_t3", mk(L_AR, 4'd0, 4'd0, 3'd0, 3'd7, 1'b1, 1'b0, 4'd3));
        step("addi_t4", mk(L_DR, 4'd0, 4'd0, 3'd0, 3'd7, 1'b1, 1'b0, 4'd4));
        step("addi_t5", mk(L_AC, 4'd0, 4'd0, 3'd2, 3'd0, 1'b0, 1'b0, 4'd5));

        for (int k = 0; k < 2; k++) begin
            ir = 16'h6040;
            dr = (k == 0) ? 16'h0000 : 16'h0001;
            fetch("isz");
            idle_t3("isz_t3");
            step("isz_t4", mk(L_DR, 4'd0, 4'd0, 3'd0, 3'd7, 1'b1, 1'b0, 4'd4));
            step("isz_t5", mk(6'd0, R_DR, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd5));
            step("isz_t6", mk(6'd0, (k == 0) ? R_PC : 4'd0, 4'd0, 3'd0, 3'd3, 1'b0, 1'b1, 4'd6));
        end

        ir = 16'h3123;
        fetch("sta");
        idle_t3("sta_t3");
        mem_ready = 1'b0;
        step("sta_wait", mk(6'd0, 4'd0, 4'd0, 3'd0, 3'd4, 1'b0, 1'b1, 4'd4));
        mem_ready = 1'b1;
        step("sta_t4", mk(6'd0, 4'd0, 4'd0, 3'd0, 3'd4, 1'b0, 1'b1, 4'd4));

        ir = 16'h7A00;
        fetch("cla");
        step("cla_cma", mk(L_AC, 4'd0, R_AC, 3'd5, 3'd0, 1'b0, 1'b0, 4'd3));
        ir = 16'h7004;  ac = 16'h0000;
        fetch("sza");
        step("sza_skip", mk(6'd0, R_PC, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd3));
        ir = 16'h7104;  ac = 16'h0005;
        fetch("cme");
        v = mk(6'd0, 4'd0, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd3);
        v.e_ctl = 2'b01;
        step("cme_noskip", v);
        ir = 16'h7008;  ac = 16'h8000;
        fetch("sna");
        step("sna_skip", mk(6'd0, R_PC, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd3));

        ir = 16'hF800;
        fetch("inp");
        v = mk(L_AC, 4'd0, 4'd0, 3'd4, 3'd0, 1'b0, 1'b0, 4'd3);
        v.fgi_clr = 1'b1;
        step("inp", v);
        ir = 16'hF400;
        fetch("out");
        v = mk(6'd0, 4'd0, 4'd0, 3'd0, 3'd4, 1'b0, 1'b0, 4'd3);
        v.outr_ld = 1'b1;  v.fgo_clr = 1'b1;
        step("out", v);

        ir = 16'hF080;
        fetch("ion");
        idle_t3("ion_t3");
`ifdef CU_IRQ_EN
        exp_ien = 1'b1;
`endif
        fgi = 1'b1;
        ir = 16'h7800;
        fetch("cla2");
        step("cla2_t3", mk(6'd0, 4'd0, R_AC, 3'd0, 3'd0, 1'b0, 1'b0, 4'd3));
`ifdef CU_IRQ_EN
        step("irq_t0", mk(L_TR, 4'd0, R_AR, 3'd0, 3'd2, 1'b0, 1'b0, 4'd0));
        step("irq_t1", mk(6'd0, 4'd0, R_PC, 3'd0, 3'd6, 1'b0, 1'b1, 4'd1));
        step("irq_t2", mk(6'd0, R_PC, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd2));
        exp_ien = 1'b0;
`endif

        ir = 16'h7001;
        fetch("hlt");
        idle_t3("hlt_t3");
        v = '0;
        v.halted = 1'b1;
        for (int i = 0; i < 10; i++) step("halted", v);
        reset = 1'b0;
        v = mk(6'd0, 4'd0, R_PC, 3'd0, 3'd0, 1'b0, 1'b0, 4'd0);
        v.halted = 1'b1;
        step("hlt_rst", v);
        reset = 1'b1;
        step("post_rst_t0", mk(L_AR, 4'd0, 4'd0, 3'd0, 3'd2, 1'b0, 1'b0, 4'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
